// File: rtl/serial_out_pkg.sv
// -----------------------------------------------------------------------------
// serial_out_pkg
// Shared definitions for the serial_out_arbiter slice:
//   - FSM state encodings (3 bits) and the matching state enum
//   - client index constants (LED = 0, SEG = 1)
//   - client_bits(): word width for a client index
// No ports (package).
// -----------------------------------------------------------------------------
package serial_out_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_LATCH = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_SHIFT = ST_SHIFT,
    S_LATCH = ST_LATCH,
    S_GAP   = ST_GAP
  } state_t;

  localparam logic CLI_LED = 1'b0;
  localparam logic CLI_SEG = 1'b1;

  function automatic int unsigned client_bits(input logic        cli,
                                              input int unsigned led_bits,
                                              input int unsigned seg_bits);
    return (cli == CLI_SEG) ? seg_bits : led_bits;
  endfunction

endpackage

// File: rtl/serial_out_rr2.sv
// -----------------------------------------------------------------------------
// serial_out_rr2
// Two-input round-robin arbiter. Grant is combinational from the request
// vector and the last-served pointer; the pointer only moves on the GAP strobe
// so it reflects completed transfers, not merely granted ones.
// Ports:
//   i_clk      system clock
//   i_rst      asynchronous active-high reset (pointer -> SEG, so LED wins
//              the first tie)
//   i_req      request vector [0]=LED, [1]=SEG
//   i_gap_stb  one-cycle strobe: transfer finished, record its owner
//   i_owner    client index of the finishing transfer
//   o_grant    one-hot grant, 0 when no request
// -----------------------------------------------------------------------------
module serial_out_rr2
  import serial_out_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_gap_stb,
  input  logic       i_owner,
  output logic [1:0] o_grant
);

  logic r_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          r_last <= CLI_SEG;
    else if (i_gap_stb) r_last <= i_owner;
  end

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      // tie: serve whoever was not served last
      2'b11:   o_grant = (r_last == CLI_SEG) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/serial_out_arbiter.sv
// -----------------------------------------------------------------------------
// serial_out_arbiter
// Shares one serial shift-out channel between the 16-bit LED bank and the
// 64-bit seven-segment display. Round-robin between the two; each transfer
// captures the winner's word, shifts it MSB-first on a divided sclk, then
// pulses that client's latch enable.
//
// Optional build macro: SERIAL_OUT_SOUT_INVERT_EN
//   defined   -> sout carries the complement of each data bit
//   undefined -> sout carries the data bit true
//
// Ports:
//   i_clk, i_rst           clock, async active-high reset
//   i_led_req, i_led_data  LED request (level) and word
//   o_led_ack              1-cycle pulse in LOAD: LED word captured
//   i_seg_req, i_seg_data  seven-segment request (level) and word
//   o_seg_ack              1-cycle pulse in LOAD: SEG word captured
//   o_busy                 high LOAD..GAP
//   o_grant                one-hot owner ([0]=LED, [1]=SEG), 0 when idle
//   o_sclk, o_sout         serial clock / data to the shift-register chips
//   o_led_pen, o_seg_pen   latch enables
//   o_clrn                 active-low chip clear, 0 in reset
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | wait for a request, arbitrate
// LOAD  | 1 cycle: ack winner, capture its word at the end of the cycle
// SHIFT | shift N bits, CLK_DIV cycles sclk low then CLK_DIV high
// LATCH | CLK_DIV cycles: owner's pen high
// GAP   | 1 cycle: pens low, round-robin pointer takes the owner
// -----------------------------------------------------------------------------
module serial_out_arbiter
  import serial_out_pkg::*;
#(
  parameter int unsigned LED_BITS = 16,
  parameter int unsigned SEG_BITS = 64,
  parameter int unsigned CLK_DIV  = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_led_req,
  input  logic [LED_BITS-1:0] i_led_data,
  output logic                o_led_ack,
  input  logic                i_seg_req,
  input  logic [SEG_BITS-1:0] i_seg_data,
  output logic                o_seg_ack,
  output logic                o_busy,
  output logic [1:0]          o_grant,
  output logic                o_sclk,
  output logic                o_sout,
  output logic                o_led_pen,
  output logic                o_seg_pen,
  output logic                o_clrn
);

  localparam int unsigned CNT_W = $clog2(SEG_BITS + 1);
  localparam int unsigned TMR_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CLK_DIV - 1);

  state_t              r_state;
  logic [SEG_BITS-1:0] r_shreg;
  logic [CNT_W-1:0]    r_cnt;
  logic [TMR_W-1:0]    r_tmr;
  logic [1:0]          r_grant;
  logic                r_busy;
  logic                r_led_ack;
  logic                r_seg_ack;
  logic                r_sclk;
  logic                r_sout;
  logic                r_led_pen;
  logic                r_seg_pen;
  logic                r_clrn;

  logic [1:0]          w_rr_grant;
  logic                w_owner;
  logic                w_gap_stb;
  logic [SEG_BITS-1:0] w_led_ext;
  logic [SEG_BITS-1:0] w_load_word;
  logic [SEG_BITS-1:0] w_shifted;

  function automatic logic sout_bit(input logic b);
`ifdef SERIAL_OUT_SOUT_INVERT_EN
    return ~b;
`else
    return b;
`endif
  endfunction

  assign w_owner     = r_grant[CLI_SEG] ? CLI_SEG : CLI_LED;
  assign w_gap_stb   = (r_state == S_GAP);
  // LED word left-justified so both clients shift from the same MSB
  assign w_led_ext   = SEG_BITS'(i_led_data) << (SEG_BITS - LED_BITS);
  assign w_load_word = r_grant[CLI_SEG] ? i_seg_data : w_led_ext;
  assign w_shifted   = r_shreg << 1;

  serial_out_rr2 u_rr2 (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     ({i_seg_req, i_led_req}),
    .i_gap_stb (w_gap_stb),
    .i_owner   (w_owner),
    .o_grant   (w_rr_grant)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_cnt     <= '0;
      r_tmr     <= '0;
      r_grant   <= 2'b00;
      r_busy    <= 1'b0;
      r_led_ack <= 1'b0;
      r_seg_ack <= 1'b0;
      r_sclk    <= 1'b0;
      r_sout    <= 1'b0;
      r_led_pen <= 1'b0;
      r_seg_pen <= 1'b0;
      r_clrn    <= 1'b0;
    end else begin
      r_clrn    <= 1'b1;
      r_led_ack <= 1'b0;
      r_seg_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|w_rr_grant) begin
            r_state   <= S_LOAD;
            r_grant   <= w_rr_grant;
            r_busy    <= 1'b1;
            r_led_ack <= w_rr_grant[CLI_LED];
            r_seg_ack <= w_rr_grant[CLI_SEG];
          end
        end
        S_LOAD: begin
          r_shreg <= w_load_word;
          r_cnt   <= CNT_W'(client_bits(w_owner, LED_BITS, SEG_BITS));
          r_sout  <= sout_bit(w_load_word[SEG_BITS-1]);
          r_sclk  <= 1'b0;
          r_tmr   <= TMR_LOAD;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (r_tmr != '0) begin
            r_tmr <= r_tmr - TMR_W'(1);
          end else if (!r_sclk) begin
            r_sclk <= 1'b1;
            r_tmr  <= TMR_LOAD;
          end else begin
            // end of the high phase: advance to the next bit
            r_sclk  <= 1'b0;
            r_tmr   <= TMR_LOAD;
            r_shreg <= w_shifted;
            r_cnt   <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state   <= S_LATCH;
              r_led_pen <= r_grant[CLI_LED];
              r_seg_pen <= r_grant[CLI_SEG];
            end else begin
              r_sout <= sout_bit(w_shifted[SEG_BITS-1]);
            end
          end
        end
        S_LATCH: begin
          if (r_tmr != '0) begin
            r_tmr <= r_tmr - TMR_W'(1);
          end else begin
            r_led_pen <= 1'b0;
            r_seg_pen <= 1'b0;
            r_sout    <= 1'b0;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          r_state <= S_IDLE;
          r_grant <= 2'b00;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= 2'b00;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_led_ack = r_led_ack;
  assign o_seg_ack = r_seg_ack;
  assign o_busy    = r_busy;
  assign o_grant   = r_grant;
  assign o_sclk    = r_sclk;
  assign o_sout    = r_sout;
  assign o_led_pen = r_led_pen;
  assign o_seg_pen = r_seg_pen;
  assign o_clrn    = r_clrn;

endmodule

// File: tb/tb_serial_out_arbiter.sv
// -----------------------------------------------------------------------------
// tb_serial_out_arbiter
// Directed bench for serial_out_arbiter at default parameters. A monitor
// samples outputs 1 time unit after each rising edge and keeps running
// counters; the stimulus block compares deltas of those counters against
// hand-computed values. Build with +define+SERIAL_OUT_SOUT_INVERT_EN to
// exercise the inverted-sout variant.
// -----------------------------------------------------------------------------
module tb_serial_out_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        led_req = 1'b0;
  logic [15:0] led_data = '0;
  logic        seg_req = 1'b0;
  logic [63:0] seg_data = '0;
  logic        o_led_ack, o_seg_ack, o_busy, o_sclk, o_sout;
  logic        o_led_pen, o_seg_pen, o_clrn;
  logic [1:0]  o_grant;

  int n_assert = 0;
  int n_fail   = 0;

  serial_out_arbiter dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_led_req  (led_req),
    .i_led_data (led_data),
    .o_led_ack  (o_led_ack),
    .i_seg_req  (seg_req),
    .i_seg_data (seg_data),
    .o_seg_ack  (o_seg_ack),
    .o_busy     (o_busy),
    .o_grant    (o_grant),
    .o_sclk     (o_sclk),
    .o_sout     (o_sout),
    .o_led_pen  (o_led_pen),
    .o_seg_pen  (o_seg_pen),
    .o_clrn     (o_clrn)
  );

  always #5 clk = ~clk;

  // ---------------- monitor ----------------
  int          sclk_rises = 0;
  logic [63:0] cap = '0;
  int          busy_cyc = 0;
  int          led_pen_cyc = 0, seg_pen_cyc = 0;
  int          led_pen_rises = 0, seg_pen_rises = 0;
  int          ack_n = 0;
  logic [1:0]  ack_log [0:31];
  int          idle_viol = 0;
  logic        prev_sclk = 1'b0, prev_lpen = 1'b0, prev_spen = 1'b0;

  always @(posedge clk) begin
    #1;
    if (o_sclk && !prev_sclk) begin
      sclk_rises++;
      cap = {cap[62:0], o_sout};
    end
    if (o_busy) busy_cyc++;
    if (o_led_pen) led_pen_cyc++;
    if (o_seg_pen) seg_pen_cyc++;
    if (o_led_pen && !prev_lpen) led_pen_rises++;
    if (o_seg_pen && !prev_spen) seg_pen_rises++;
    if (o_led_ack || o_seg_ack) begin
      if (ack_n < 32) ack_log[ack_n] = o_grant;
      ack_n++;
    end
    if (!o_busy && (o_sclk || o_led_pen || o_seg_pen || o_led_ack || o_seg_ack))
      idle_viol++;
    prev_sclk = o_sclk;
    prev_lpen = o_led_pen;
    prev_spen = o_seg_pen;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_bits(input logic [63:0] v, input int n);
    logic [63:0] m;
    m = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
`ifdef SERIAL_OUT_SOUT_INVERT_EN
    return (~v) & m;
`else
    return v & m;
`endif
  endfunction

  task automatic chk_cap(input string tag, input logic [63:0] v, input int n);
    logic [63:0] m;
    m = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    chk(tag, cap & m, exp_bits(v, n));
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000 && o_busy; i++) @(negedge clk);
    chk(tag, {63'd0, o_busy}, 64'd0);
  endtask

  task automatic wait_ack(input bit seg, input string tag);
    for (int i = 0; i < 1000 && !(seg ? o_seg_ack : o_led_ack); i++) @(negedge clk);
    chk(tag, {63'd0, (seg ? o_seg_ack : o_led_ack)}, 64'd1);
  endtask

  // ---------------- stimulus ----------------
  int b_busy, b_rises, b_lpc, b_spc, b_lpr, b_spr, b_ack;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_grant", {62'd0, o_grant}, 64'd0);
    chk("rst_clrn", {63'd0, o_clrn}, 64'd0);
    chk("rst_sclk_sout", {62'd0, o_sclk, o_sout}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("clrn_after_rst", {63'd0, o_clrn}, 64'd1);

    // --- 1: single LED transfer ---
    b_busy = busy_cyc; b_rises = sclk_rises; b_lpc = led_pen_cyc; b_spc = seg_pen_cyc;
    led_data = 16'hA55A; led_req = 1'b1;
    @(negedge clk);
    chk("s1_ack", {63'd0, o_led_ack}, 64'd1);
    chk("s1_grant", {62'd0, o_grant}, 64'd1);
    led_req = 1'b0;
    @(negedge clk);
    chk("s1_ack_one_cycle", {63'd0, o_led_ack}, 64'd0);
    wait_idle("s1_done");
    chk("s1_busy_cycles", 64'(busy_cyc - b_busy), 64'd68);
    chk("s1_sclk_rises", 64'(sclk_rises - b_rises), 64'd16);
    chk_cap("s1_bits", 64'hA55A, 16);
    chk("s1_led_pen_cycles", 64'(led_pen_cyc - b_lpc), 64'd2);
    chk("s1_seg_pen_cycles", 64'(seg_pen_cyc - b_spc), 64'd0);
    chk("s1_grant_idle", {62'd0, o_grant}, 64'd0);

    // --- 6: 00FF pattern (inverted when the macro is defined) ---
    b_busy = busy_cyc; b_rises = sclk_rises; b_lpc = led_pen_cyc;
    led_data = 16'h00FF; led_req = 1'b1;
    @(negedge clk);
    led_req = 1'b0;
    wait_idle("s6_done");
    chk_cap("s6_bits", 64'h00FF, 16);
    chk("s6_busy_cycles", 64'(busy_cyc - b_busy), 64'd68);
    chk("s6_sclk_rises", 64'(sclk_rises - b_rises), 64'd16);
    chk("s6_led_pen_cycles", 64'(led_pen_cyc - b_lpc), 64'd2);

    // --- 2: simultaneous requests right after reset ---
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    b_rises = sclk_rises; b_spr = seg_pen_rises; b_lpr = led_pen_rises; b_spc = seg_pen_cyc;
    led_data = 16'h1234; seg_data = 64'h0123456789ABCDEF;
    led_req = 1'b1; seg_req = 1'b1;
    @(negedge clk);
    chk("s2_led_first", {62'd0, o_grant}, 64'd1);
    led_req = 1'b0;
    wait_ack(1'b1, "s2_seg_ack");
    chk("s2_seg_grant", {62'd0, o_grant}, 64'd2);
    chk_cap("s2_led_bits", 64'h1234, 16);
    seg_req = 1'b0;
    wait_idle("s2_done");
    chk_cap("s2_seg_bits", 64'h0123456789ABCDEF, 64);
    chk("s2_sclk_rises", 64'(sclk_rises - b_rises), 64'd80);
    chk("s2_seg_pen_pulses", 64'(seg_pen_rises - b_spr), 64'd1);
    chk("s2_seg_pen_cycles", 64'(seg_pen_cyc - b_spc), 64'd2);
    chk("s2_led_pen_pulses", 64'(led_pen_rises - b_lpr), 64'd1);

    // --- 3: both held for four transfers ---
    b_ack = ack_n; b_lpr = led_pen_rises; b_spr = seg_pen_rises;
    led_data = 16'h0F0F; seg_data = 64'hDEADBEEFCAFEF00D;
    led_req = 1'b1; seg_req = 1'b1;
    for (int i = 0; i < 2000 && (ack_n - b_ack) < 4; i++) @(negedge clk);
    chk("s3_four_acks_seen", 64'(ack_n - b_ack), 64'd4);
    led_req = 1'b0; seg_req = 1'b0;
    wait_idle("s3_done");
    chk("s3_ack_total", 64'(ack_n - b_ack), 64'd4);
    chk("s3_grant0", {62'd0, ack_log[b_ack + 0]}, 64'd1);
    chk("s3_grant1", {62'd0, ack_log[b_ack + 1]}, 64'd2);
    chk("s3_grant2", {62'd0, ack_log[b_ack + 2]}, 64'd1);
    chk("s3_grant3", {62'd0, ack_log[b_ack + 3]}, 64'd2);
    chk("s3_led_pens", 64'(led_pen_rises - b_lpr), 64'd2);
    chk("s3_seg_pens", 64'(seg_pen_rises - b_spr), 64'd2);
    chk_cap("s3_last_seg_bits", 64'hDEADBEEFCAFEF00D, 64);

    // --- 4: data change after capture is ignored ---
    led_data = 16'h3C3C; led_req = 1'b1;
    wait_ack(1'b0, "s4_ack");
    led_req = 1'b0;
    @(negedge clk); @(negedge clk);
    led_data = 16'hFFFF;
    wait_idle("s4_done");
    chk_cap("s4_captured_bits", 64'h3C3C, 16);
    led_req = 1'b1;
    wait_ack(1'b0, "s4_ack2");
    led_req = 1'b0;
    wait_idle("s4_done2");
    chk_cap("s4_next_bits", 64'hFFFF, 16);

    // --- 5: reset mid-SEG transfer ---
    b_spr = seg_pen_rises;
    seg_data = 64'hAAAA5555AAAA5555; seg_req = 1'b1;
    wait_ack(1'b1, "s5_ack");
    b_rises = sclk_rises;
    for (int i = 0; i < 500 && (sclk_rises - b_rises) < 8; i++) @(negedge clk);
    chk("s5_eight_rises", 64'(sclk_rises - b_rises), 64'd8);
    rst = 1'b1; seg_req = 1'b0;
    #1;
    chk("s5_outputs_zero",
        {53'd0, o_led_ack, o_seg_ack, o_busy, o_grant, o_sclk, o_sout, o_led_pen, o_seg_pen, o_clrn},
        64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    chk("s5_clrn_before_edge", {63'd0, o_clrn}, 64'd0);
    @(negedge clk);
    chk("s5_clrn_after_edge", {63'd0, o_clrn}, 64'd1);
    chk("s5_no_seg_pen", 64'(seg_pen_rises - b_spr), 64'd0);
    b_lpc = led_pen_cyc; b_busy = busy_cyc;
    led_data = 16'h5A3C; led_req = 1'b1;
    @(negedge clk);
    chk("s5_led_served", {61'd0, o_led_ack, o_grant}, 64'd5);
    led_req = 1'b0;
    wait_idle("s5_done");
    chk_cap("s5_led_bits", 64'h5A3C, 16);
    chk("s5_led_pen_cycles", 64'(led_pen_cyc - b_lpc), 64'd2);
    chk("s5_busy_cycles", 64'(busy_cyc - b_busy), 64'd68);

    repeat (3) @(negedge clk);
    chk("idle_quiet", 64'(idle_viol), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
